i_type_core: RTL

I_TYPE_CORE -- requirements
Module: i_type_core

---
 rtl/i_type_pkg.sv | 40 ++++
 rtl/i_type_alu.sv | 41 ++++
 rtl/i_type_core.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/i_type_pkg.sv
// Shared encodings and enums for the I-type core.
// Opcode/funct constants, FSM states, ALU operations.
package i_type_pkg;

  localparam logic [6:0] OPC_OPIMM = 7'b0010011;

  localparam logic [2:0] F3_ADDI  = 3'b000;
  localparam logic [2:0] F3_SLLI  = 3'b001;
  localparam logic [2:0] F3_SLTI  = 3'b010;
  localparam logic [2:0] F3_SLTIU = 3'b011;
  localparam logic [2:0] F3_XORI  = 3'b100;
  localparam logic [2:0] F3_SRI   = 3'b101;
  localparam logic [2:0] F3_ORI   = 3'b110;
  localparam logic [2:0] F3_ANDI  = 3'b111;

  localparam logic [6:0] F7_BASE = 7'h00;
  localparam logic [6:0] F7_ALT  = 7'h20;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_WB,
    S_HALT
  } state_t;

  typedef enum logic [3:0] {
    ALU_ADD,
    ALU_SLT,
    ALU_SLTU,
    ALU_XOR,
    ALU_OR,
    ALU_AND,
    ALU_SLL,
    ALU_SRL,
    ALU_SRA
  } alu_op_t;

endpackage

// File: rtl/i_type_alu.sv
// Combinational ALU for OP-IMM instructions.
// Shift amount is 5 bits on RV32, 6 bits on RV64.
module i_type_alu
  import i_type_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  alu_op_t           alu_op,
  input  logic [XLEN-1:0]   op1,
  input  logic [XLEN-1:0]   imm,
  output logic [XLEN-1:0]   res
);

  localparam int SW = (XLEN == 64) ? 6 : 5;

  logic [SW-1:0] sh;
  logic          lt_s;
  logic          lt_u;

  assign sh   = imm[SW-1:0];
  assign lt_s = $signed(op1) < $signed(imm);
  assign lt_u = op1 < imm;

  // Select the result for the decoded operation
  always_comb begin
    res = '0;
    unique case (alu_op)
      ALU_ADD:  res = op1 + imm;
      ALU_SLT:  res = {{(XLEN-1){1'b0}}, lt_s};
      ALU_SLTU: res = {{(XLEN-1){1'b0}}, lt_u};
      ALU_XOR:  res = op1 ^ imm;
      ALU_OR:   res = op1 | imm;
      ALU_AND:  res = op1 & imm;
      ALU_SLL:  res = op1 << sh;
      ALU_SRL:  res = op1 >> sh;
      ALU_SRA:  res = XLEN'($signed(op1) >>> sh);
      default:  res = '0;
    endcase
  end

endmodule

// File: rtl/i_type_core.sv
// Multi-cycle OP-IMM core: FETCH/DECODE/EXEC/WB per word.
// Halts on illegal encodings, the zero word, or PC wrap.
module i_type_core
  import i_type_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int IMEM_DEPTH = 64,
  parameter int NREGS      = 32
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          imem_we,
  input  logic [$clog2(IMEM_DEPTH)-1:0] imem_waddr,
  input  logic [31:0]                   imem_wdata,
  input  logic                          start,
  output logic [31:0]                   im,
  output logic [XLEN-1:0]               op1,
  output logic [XLEN-1:0]               res,
  output logic [XLEN-1:0]               wrt,
  output logic [$clog2(IMEM_DEPTH)+1:0] pc,
  output logic                          busy,
  output logic                          halted,
  output logic                          illegal
);

  localparam int AW = $clog2(IMEM_DEPTH);
  localparam int PW = AW + 2;
  localparam int RW = $clog2(NREGS);
  localparam bit SMALLRF = (NREGS < 32);

  state_t state, nstate;

  logic [31:0]     imem [IMEM_DEPTH];
  logic [XLEN-1:0] rf   [NREGS];

  logic [XLEN-1:0] imm_q;
  logic [XLEN-1:0] alu_res;
  logic [XLEN-1:0] rs1v;
  logic [XLEN-1:0] sext;
  logic [PW-1:0]   pc_nxt;

  logic [6:0] opc;
  logic [4:0] rd;
  logic [4:0] rs1;
  logic [2:0] f3;
  logic [6:0] fhi;

  alu_op_t aop;
  logic    fok;
  logic    reg_bad;
  logic    sentinel;
  logic    bad;
  logic    wrap;
  logic    stop;
  logic    do_wr;
  logic    idle_like;

  assign opc = im[6:0];
  assign rd  = im[11:7];
  assign f3  = im[14:12];
  assign rs1 = im[19:15];
  // On RV64 bit 25 belongs to the shift amount
  assign fhi = (XLEN == 64) ? {im[31:26], 1'b0} : im[31:25];

  assign sext     = {{(XLEN-12){im[31]}}, im[31:20]};
  assign sentinel = (im == 32'h0);
  assign reg_bad  = SMALLRF & (rs1[4] | rd[4]);
  assign bad      = ~sentinel &
                    ((opc != OPC_OPIMM) | ~fok | reg_bad);
  assign do_wr    = ~bad & ~sentinel & (rd != 5'd0);

  assign pc_nxt = pc + PW'(4);
  assign wrap   = (pc_nxt == '0);
  assign stop   = bad | sentinel | wrap;

  assign rs1v = (rs1 == 5'd0) ? '0 : rf[rs1[RW-1:0]];

  assign idle_like = (state == S_IDLE) | (state == S_HALT);
  assign busy      = ~idle_like;
  assign halted    = (state == S_HALT);

  // Decode funct3/funct7 into an ALU op and a legality flag
  always_comb begin
    aop = ALU_ADD;
    fok = 1'b0;
    unique case (1'b1)
      (f3 == F3_ADDI):  begin aop = ALU_ADD;  fok = 1'b1; end
      (f3 == F3_SLTI):  begin aop = ALU_SLT;  fok = 1'b1; end
      (f3 == F3_SLTIU): begin aop = ALU_SLTU; fok = 1'b1; end
      (f3 == F3_XORI):  begin aop = ALU_XOR;  fok = 1'b1; end
      (f3 == F3_ORI):   begin aop = ALU_OR;   fok = 1'b1; end
      (f3 == F3_ANDI):  begin aop = ALU_AND;  fok = 1'b1; end
      (f3 == F3_SLLI): begin
        aop = ALU_SLL;
        fok = (fhi == F7_BASE);
      end
      (f3 == F3_SRI): begin
        aop = fhi[5] ? ALU_SRA : ALU_SRL;
        fok = (fhi == F7_BASE) | (fhi == F7_ALT);
      end
      default: ;
    endcase
  end

  i_type_alu #(.XLEN(XLEN)) u_alu (
    .alu_op (aop),
    .op1    (op1),
    .imm    (imm_q),
    .res    (alu_res)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= nstate;
  end

  // Next-state: fixed four-cycle instruction, start only when not busy
  always_comb begin
    nstate = state;
    unique case (state)
      S_IDLE:   if (start) nstate = S_FETCH;
      S_HALT:   if (start) nstate = S_FETCH;
      S_FETCH:  nstate = S_DECODE;
      S_DECODE: nstate = S_EXEC;
      S_EXEC:   nstate = S_WB;
      S_WB:     nstate = stop ? S_HALT : S_FETCH;
      default:  nstate = S_IDLE;
    endcase
  end

  // Instruction memory: writable only while stopped, never reset
  always_ff @(posedge clk) begin
    if (imem_we && idle_like) imem[imem_waddr] <= imem_wdata;
  end

  // Datapath registers, one stage per state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      im      <= '0;
      op1     <= '0;
      imm_q   <= '0;
      res     <= '0;
      wrt     <= '0;
      pc      <= '0;
      illegal <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE, S_HALT: begin
          if (start) begin
            pc      <= '0;
            illegal <= 1'b0;
          end
        end
        S_FETCH: im <= imem[pc[PW-1:2]];
        S_DECODE: begin
          op1   <= rs1v;
          imm_q <= sext;
        end
        S_EXEC: begin
          res <= alu_res;
          if (bad) illegal <= 1'b1;
        end
        S_WB: begin
          wrt <= do_wr ? res : '0;
          if (!wrap) pc <= pc_nxt;
        end
        default: ;
      endcase
    end
  end

  // Register file: cleared only by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) rf[i] <= '0;
    end else if (state == S_WB && do_wr) begin
      rf[rd[RW-1:0]] <= res;
    end
  end

endmodule
